// File: rtl/button_event_queue_if.sv
// button_event_queue_if
// Event handshake between the button event queue (master, producer) and the
// UI/dialer FSM (slave, consumer).
//   event_code   : code of the head event, 0 when the queue is empty
//   event_repeat : head event is an auto-repeat (0 = initial press)
//   event_valid  : queue non-empty
//   event_ready  : consumer takes the head event on an edge with valid & ready
interface button_event_queue_if;
  logic [3:0] event_code;
  logic       event_repeat;
  logic       event_valid;
  logic       event_ready;

  modport master (
    output event_code,
    output event_repeat,
    output event_valid,
    input  event_ready
  );

  modport slave (
    input  event_code,
    input  event_repeat,
    input  event_valid,
    output event_ready
  );
endinterface

// File: rtl/button_event_queue.sv
// button_event_queue
// Turns the nine resolved button levels into discrete press events, with
// auto-repeat on held buttons selected by REPEAT_MASK. Events go into a
// 4-entry first-word-fall-through queue read over a valid/ready handshake.
//   clk, reset          : clock, synchronous active-high reset
//   button*_in          : resolved levels; codes 0-3, 4 enter, 5 left,
//                         6 right, 7 up, 8 down
//   ev (master)         : head event code/repeat/valid, consumer ready
//   overflow            : one-cycle pulse after an event was dropped (full)
//   button_held         : a button is currently tracked as held
module button_event_queue #(
  parameter int unsigned HOLD_CYCLES   = 32'd13_500_000,
  parameter int unsigned REPEAT_CYCLES = 32'd2_700_000,
  parameter logic [8:0]  REPEAT_MASK   = 9'h1E0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        button0_in,
  input  logic                        button1_in,
  input  logic                        button2_in,
  input  logic                        button3_in,
  input  logic                        button_enter_in,
  input  logic                        button_left_in,
  input  logic                        button_right_in,
  input  logic                        button_up_in,
  input  logic                        button_down_in,
  button_event_queue_if.master        ev,
  output logic                        overflow,
  output logic                        button_held
);

  localparam logic [23:0] HOLD_LOAD   = 24'(HOLD_CYCLES - 32'd1);
  localparam logic [23:0] REPEAT_LOAD = 24'(REPEAT_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Lowest set bit wins so simultaneous highs (a resolver fault) still give
  // one deterministic code. Result is {valid, code}.
  function automatic logic [4:0] encode_lowest(input logic [8:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 8; i >= 0; i--) begin
      if (v[i]) begin
        r = {1'b1, 4'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Widened copy of the mask so any 4-bit code indexes it safely.
  function automatic logic repeat_enabled(input logic [3:0] code);
    logic [15:0] m;
    m = {7'd0, REPEAT_MASK};
    return m[code];
  endfunction

  logic [8:0]  btn_s;
  logic [8:0]  btn_q;
  logic [4:0]  enc_s;
  logic        act_valid_s;
  logic [3:0]  act_code_s;

  state_t      state_q, state_d;
  logic [3:0]  held_code_q, held_code_d;
  logic [23:0] cnt_q, cnt_d;
  logic        held_q, held_d;
  logic        push_s;
  logic [4:0]  push_data_s;

  logic [4:0]  mem_q [4];
  logic [4:0]  mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        pop_s;
  logic        full_s;
  logic        wr_en_s;
  logic        ovf_q, ovf_d;
  logic [3:0]  code_q, code_d;
  logic        rep_q, rep_d;
  logic        valid_q, valid_d;

  assign btn_s = {button_down_in, button_up_in, button_right_in, button_left_in,
                  button_enter_in, button3_in, button2_in, button1_in, button0_in};

  assign enc_s       = encode_lowest(btn_q);
  assign act_valid_s = enc_s[4];
  assign act_code_s  = enc_s[3:0];

  // Press/hold/repeat decision on the registered button vector.
  always_comb begin
    state_d     = state_q;
    held_code_d = held_code_q;
    cnt_d       = cnt_q;
    held_d      = held_q;
    push_s      = 1'b0;
    push_data_s = 5'd0;
    case (state_q)
      ST_IDLE: begin
        if (act_valid_s) begin
          push_s      = 1'b1;
          push_data_s = {1'b0, act_code_s};
          state_d     = ST_HOLD;
          held_code_d = act_code_s;
          cnt_d       = HOLD_LOAD;
          held_d      = 1'b1;
        end else begin
          held_d      = 1'b0;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!act_valid_s) begin
          state_d     = ST_IDLE;
          held_d      = 1'b0;
        end else if (act_code_s != held_code_q) begin
          // Direct handover X -> Y counts as a fresh press of Y.
          push_s      = 1'b1;
          push_data_s = {1'b0, act_code_s};
          state_d     = ST_HOLD;
          held_code_d = act_code_s;
          cnt_d       = HOLD_LOAD;
        end else if (cnt_q == 24'd0) begin
          if (repeat_enabled(held_code_q)) begin
            push_s      = 1'b1;
            push_data_s = {1'b1, held_code_q};
            state_d     = ST_REPEAT;
            cnt_d       = REPEAT_LOAD;
          end else begin
            // Non-repeating button: park with the counter frozen at 0.
            cnt_d       = 24'd0;
          end
        end else begin
          cnt_d       = cnt_q - 24'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        held_d      = 1'b0;
      end
    endcase
  end

  // Queue next state; a full queue still accepts a push when the head pops
  // on the same edge, and the head registers follow the post-edge contents.
  always_comb begin
    pop_s   = ev.event_ready & (count_q != 3'd0);
    full_s  = (count_q == 3'd4);
    wr_en_s = push_s & (~full_s | pop_s);
    ovf_d   = push_s & full_s & ~pop_s;

    mem_d = mem_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = push_data_s;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end

    wr_ptr_d = wr_ptr_q + {1'b0, wr_en_s};
    rd_ptr_d = rd_ptr_q + {1'b0, pop_s};

    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    if (count_d != 3'd0) begin
      valid_d = 1'b1;
      code_d  = mem_d[rd_ptr_d][3:0];
      rep_d   = mem_d[rd_ptr_d][4];
    end else begin
      valid_d = 1'b0;
      code_d  = 4'd0;
      rep_d   = 1'b0;
    end
  end

  // All state: input register, FSM, queue and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q       <= 9'd0;
      state_q     <= ST_IDLE;
      held_code_q <= 4'd0;
      cnt_q       <= 24'd0;
      held_q      <= 1'b0;
      mem_q       <= '{default: 5'd0};
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      ovf_q       <= 1'b0;
      code_q      <= 4'd0;
      rep_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      btn_q       <= btn_s;
      state_q     <= state_d;
      held_code_q <= held_code_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      code_q      <= code_d;
      rep_q       <= rep_d;
      valid_q     <= valid_d;
    end
  end

  assign ev.event_code   = code_q;
  assign ev.event_repeat = rep_q;
  assign ev.event_valid  = valid_q;
  assign overflow        = ovf_q;
  assign button_held     = held_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Self-checking bench for button_event_queue (HOLD_CYCLES=8, REPEAT_CYCLES=4).
// A queue-based reference model tracks press age and emits events from the
// timing rules; a vector table and directed sequences add fixed expectations.
module tb_button_event_queue;

  localparam int         HOLD = 8;
  localparam int         REP  = 4;
  localparam logic [8:0] MASK = 9'h1E0;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] btn;
  logic       overflow;
  logic       button_held;

  button_event_queue_if bus();

  button_event_queue #(
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP),
    .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button0_in(btn[0]),
    .button1_in(btn[1]),
    .button2_in(btn[2]),
    .button3_in(btn[3]),
    .button_enter_in(btn[4]),
    .button_left_in(btn[5]),
    .button_right_in(btn[6]),
    .button_up_in(btn[7]),
    .button_down_in(btn[8]),
    .ev(bus.master),
    .overflow(overflow),
    .button_held(button_held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovf_seen = 0;

  // reference model state
  logic [8:0] m_in = 9'd0;
  bit         m_held = 1'b0;
  int         m_code = 0;
  int         m_age = 0;
  logic [4:0] m_q[$];
  bit         m_ovf = 1'b0;

  // events seen at the DUT head while ready=1
  int log_t[$];
  int log_code[$];
  int log_rep[$];

  typedef struct {
    logic       rst;
    logic [8:0] b;
    logic       rdy;
    logic       v;
    logic [3:0] code;
    logic       rep;
    logic       ovf;
    logic       held;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lowest(input logic [8:0] v);
    for (int i = 0; i < 9; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int c;
    bit push;
    bit pop;
    bit ovf;
    logic [4:0] evd;
    if (reset) begin
      m_in = 9'd0; m_held = 1'b0; m_code = 0; m_age = 0; m_q.delete(); m_ovf = 1'b0;
    end else begin
      c = lowest(m_in);
      push = 1'b0;
      evd = 5'd0;
      if (!m_held) begin
        if (c >= 0) begin
          push = 1'b1; evd = {1'b0, 4'(c)}; m_held = 1'b1; m_code = c; m_age = 0;
        end
      end else if (c < 0) begin
        m_held = 1'b0;
      end else if (c != m_code) begin
        push = 1'b1; evd = {1'b0, 4'(c)}; m_code = c; m_age = 0;
      end else begin
        m_age++;
        if (MASK[m_code] && (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0))) begin
          push = 1'b1; evd = {1'b1, 4'(m_code)};
        end
      end
      pop = bus.event_ready && (m_q.size() > 0);
      ovf = push && (m_q.size() == 4) && !pop;
      if (pop) void'(m_q.pop_front());
      if (push && !ovf) m_q.push_back(evd);
      m_ovf = ovf;
      m_in = btn;
    end
  endtask

  task automatic compare_all();
    int ecode;
    int erep;
    ecode = (m_q.size() > 0) ? int'(m_q[0][3:0]) : 0;
    erep  = (m_q.size() > 0) ? int'(m_q[0][4]) : 0;
    check("valid", bus.event_valid, (m_q.size() > 0) ? 1 : 0);
    check("code", bus.event_code, ecode);
    check("repeat", bus.event_repeat, erep);
    check("overflow", overflow, m_ovf);
    check("held", button_held, m_held);
    if (overflow) ovf_seen++;
    if (bus.event_valid && bus.event_ready) begin
      log_t.push_back(cyc);
      log_code.push_back(bus.event_code);
      log_rep.push_back(bus.event_repeat);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic hold(input logic [8:0] b, input int n);
    btn = b;
    repeat (n) step();
  endtask

  task automatic clear_log();
    log_t.delete(); log_code.delete(); log_rep.delete();
  endtask

  int rep_off[7] = '{0, 8, 12, 16, 20, 24, 28};
  int rc;

  initial begin
    reset = 1'b1;
    btn = 9'd0;
    bus.event_ready = 1'b1;

    //          rst   b       rdy   v     code  rep   ovf   held
    tbl[0]  = '{1'b1, 9'h000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 9'h000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 9'h004, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 9'h000, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 9'h000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 9'h000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 9'h001, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 9'h002, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 9'h002, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 9'h000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 9'h000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

    // reset state, button2 pulse, 0 -> 1 handover
    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst;
      btn = tbl[i].b;
      bus.event_ready = tbl[i].rdy;
      step();
      check("tbl_valid", bus.event_valid, tbl[i].v);
      check("tbl_code", bus.event_code, tbl[i].code);
      check("tbl_repeat", bus.event_repeat, tbl[i].rep);
      check("tbl_overflow", overflow, tbl[i].ovf);
      check("tbl_held", button_held, tbl[i].held);
    end

    // auto-repeat on up
    clear_log();
    hold(9'h080, 30);
    hold(9'h000, 4);
    check("rep_count", log_t.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < log_t.size()) begin
        check("rep_offset", log_t[i] - log_t[0], rep_off[i]);
        check("rep_code", log_code[i], 7);
        check("rep_flag", log_rep[i], (i > 0) ? 1 : 0);
      end
    end
    check("rep_released", button_held, 0);

    // masked button 0
    clear_log();
    hold(9'h001, 30);
    check("mask_held", button_held, 1);
    hold(9'h000, 4);
    check("mask_count", log_t.size(), 1);
    if (log_t.size() > 0) begin
      check("mask_code", log_code[0], 0);
      check("mask_flag", log_rep[0], 0);
    end
    check("mask_released", button_held, 0);

    // overflow: five presses with ready low
    bus.event_ready = 1'b0;
    ovf_seen = 0;
    for (int b = 0; b < 5; b++) begin
      hold(9'(1 << b), 1);
      hold(9'h000, 3);
    end
    check("ovf_pulses", ovf_seen, 1);
    bus.event_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", bus.event_valid, 1);
      check("drain_code", bus.event_code, i);
      step();
    end
    check("drain_empty", bus.event_valid, 0);

    // repeat pushed into a full queue while the head pops: no overflow
    bus.event_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      hold(9'(1 << b), 1);
      hold(9'h000, 3);
    end
    hold(9'h080, 2);
    hold(9'h080, 7);
    bus.event_ready = 1'b1;
    hold(9'h080, 1);
    check("full_rep_ovf", overflow, 0);
    check("full_rep_head", bus.event_code, 1);
    hold(9'h000, 10);
    check("full_rep_empty", bus.event_valid, 0);

    // reset in the middle of a right-button hold
    bus.event_ready = 1'b1;
    hold(9'h040, 2);
    hold(9'h040, 4);
    reset = 1'b1;
    step();
    check("rst_valid", bus.event_valid, 0);
    check("rst_held", button_held, 0);
    reset = 1'b0;
    rc = cyc;
    clear_log();
    hold(9'h040, 14);
    hold(9'h000, 4);
    check("rst_log", (log_t.size() >= 2) ? 1 : 0, 1);
    if (log_t.size() >= 2) begin
      check("rst_press_t", log_t[0] - rc, 2);
      check("rst_press", {log_rep[0], log_code[0][3:0]}, 6);
      check("rst_repeat", {log_rep[1], log_code[1][3:0]}, 22);
      check("rst_rep_t", log_t[1] - log_t[0], 8);
    end

    // randomized traffic against the model
    for (int n = 0; n < 1500; ) begin
      int r;
      int len;
      logic [8:0] b;
      r = $urandom_range(0, 9);
      if (r < 3) b = 9'h000;
      else if (r < 8) b = 9'(1 << $urandom_range(0, 8));
      else b = 9'($urandom);
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        btn = b;
        bus.event_ready = ($urandom_range(0, 3) != 0);
        reset = ($urandom_range(0, 299) == 0);
        step();
        n++;
      end
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
